// File: rtl/ids_bus_pkg.sv
// Shared constants and types for the IDS data-side bus arbiter.
// Master indices fix the round-robin order: SPI, then DMEM, then DMA.
package ids_bus_pkg;

    localparam int N_MST    = 3;
    localparam int MST_SPI  = 0;
    localparam int MST_DMEM = 1;
    localparam int MST_DMA  = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_state_t;

endpackage

// File: rtl/ids_rr_picker.sv
// Combinational round-robin pick: first requester after `last`, skipping excluded masters.
// Zero latency; no backpressure, valid is low when nobody eligible requests.
module ids_rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    input  logic [N-1:0]     excl,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [N-1:0]     cand;
    logic [IDX_W-1:0] idx;

    assign cand = req & ~excl;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDX_W'((int'(last) + i) % N);
            if (!valid && cand[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/ids_bus_arbiter.sv
// Round-robin owner of the IDS data-side slave port, bounded hold, 1-cycle read return routing.
// Grant lands one edge after request; non-granted masters simply wait with i_req held high.
module ids_bus_arbiter #(
    parameter int XLEN     = 32,
    parameter int N_MST    = ids_bus_pkg::N_MST,
    parameter int MAX_HOLD = 16,
    parameter int RD_LAT   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_MST-1:0]      i_req,
    output logic [N_MST-1:0]      o_gnt,
    input  logic [N_MST*XLEN-1:0] i_m_addr,
    input  logic [N_MST-1:0]      i_m_write,
    input  logic [N_MST-1:0]      i_m_read,
    input  logic [N_MST*4-1:0]    i_m_size,
    input  logic [N_MST*XLEN-1:0] i_m_wdata,
    output logic [N_MST*XLEN-1:0] o_m_rdata,
    output logic [N_MST-1:0]      o_m_rvalid,
    output logic [XLEN-1:0]       o_s_addr,
    output logic                  o_s_write,
    output logic                  o_s_read,
    output logic [3:0]            o_s_size,
    output logic [XLEN-1:0]       o_s_wdata,
    input  logic [XLEN-1:0]       i_s_rdata,
    output logic                  o_busy
);

    import ids_bus_pkg::*;

    localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    if (RD_LAT != 1) begin : g_bad_rd_lat
        $error("ids_bus_arbiter only supports a slave read latency of 1");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic [IDX_W-1:0] rd_owner;
    logic             rd_pend;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_base;
    logic             contended;
    logic             owner_req;
    logic             others_req;
    logic [N_MST-1:0] excl;

    function automatic logic [N_MST-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_MST'(1) << idx;
    endfunction

    assign owner_req  = |(i_req & o_gnt);
    assign others_req = |(i_req & ~o_gnt);
    assign excl       = (state == ARB_OWN) ? o_gnt : '0;
    assign o_busy     = |o_gnt;

    // The hold budget only runs across consecutive contended cycles; an
    // uncontested stretch (counter parked at saturation) restarts it from zero.
    assign hold_base  = contended ? hold_cnt : '0;

    ids_rr_picker #(
        .N     (N_MST),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (i_req),
        .last   (last_winner),
        .excl   (excl),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ARB_IDLE;
            o_gnt       <= '0;
            owner       <= '0;
            last_winner <= IDX_W'(N_MST - 1);
            hold_cnt    <= '0;
            contended   <= 1'b0;
            rd_pend     <= 1'b0;
            rd_owner    <= '0;
        end else begin
            rd_pend  <= o_s_read;
            rd_owner <= owner;
            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        state       <= ARB_OWN;
                        o_gnt       <= onehot(pick_idx);
                        owner       <= pick_idx;
                        last_winner <= pick_idx;
                        hold_cnt    <= '0;
                        contended   <= 1'b0;
                    end
                end
                ARB_OWN: begin
                    if (!owner_req) begin
                        hold_cnt  <= '0;
                        contended <= 1'b0;
                        if (pick_vld) begin
                            o_gnt       <= onehot(pick_idx);
                            owner       <= pick_idx;
                            last_winner <= pick_idx;
                        end else begin
                            state <= ARB_IDLE;
                            o_gnt <= '0;
                        end
                    end else if (!others_req) begin
                        contended <= 1'b0;
                        if (hold_cnt != CNT_W'(MAX_HOLD)) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (hold_base == CNT_W'(MAX_HOLD - 1)) begin
                        o_gnt       <= onehot(pick_idx);
                        owner       <= pick_idx;
                        last_winner <= pick_idx;
                        hold_cnt    <= '0;
                        contended   <= 1'b0;
                    end else begin
                        hold_cnt  <= hold_base + 1'b1;
                        contended <= 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        o_s_addr  = '0;
        o_s_write = 1'b0;
        o_s_read  = 1'b0;
        o_s_size  = '0;
        o_s_wdata = '0;
        for (int m = 0; m < N_MST; m++) begin
            if (o_gnt[m]) begin
                o_s_addr  = i_m_addr[m*XLEN +: XLEN];
                o_s_write = i_m_write[m];
                o_s_read  = i_m_read[m];
                o_s_size  = i_m_size[m*4 +: 4];
                o_s_wdata = i_m_wdata[m*XLEN +: XLEN];
            end
        end
    end

    // Read data follows the master that issued the read, not the current owner.
    always_comb begin
        o_m_rdata  = '0;
        o_m_rvalid = '0;
        for (int m = 0; m < N_MST; m++) begin
            if (rd_pend && rd_owner == IDX_W'(m)) begin
                o_m_rvalid[m]              = 1'b1;
                o_m_rdata[m*XLEN +: XLEN]  = i_s_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ids_bus_arbiter.sv
// Bench for ids_bus_arbiter: directed scenarios plus random traffic against a queue-free ownership model.
module tb_ids_bus_arbiter;
    import ids_bus_pkg::*;

    localparam int XLEN     = 32;
    localparam int NM       = 3;
    localparam int MAX_HOLD = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [NM-1:0]     i_req;
    logic [NM-1:0]     o_gnt;
    logic [NM*XLEN-1:0] i_m_addr;
    logic [NM-1:0]     i_m_write;
    logic [NM-1:0]     i_m_read;
    logic [NM*4-1:0]   i_m_size;
    logic [NM*XLEN-1:0] i_m_wdata;
    logic [NM*XLEN-1:0] o_m_rdata;
    logic [NM-1:0]     o_m_rvalid;
    logic [XLEN-1:0]   o_s_addr;
    logic              o_s_write;
    logic              o_s_read;
    logic [3:0]        o_s_size;
    logic [XLEN-1:0]   o_s_wdata;
    logic [XLEN-1:0]   i_s_rdata;
    logic              o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: current owner (-1 none), last winner, consecutive contended cycles, pending read owner.
    int m_owner, m_last, m_run, m_pend;

    ids_bus_arbiter #(.XLEN(XLEN), .N_MST(NM), .MAX_HOLD(MAX_HOLD), .RD_LAT(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .o_gnt(o_gnt),
        .i_m_addr(i_m_addr), .i_m_write(i_m_write), .i_m_read(i_m_read),
        .i_m_size(i_m_size), .i_m_wdata(i_m_wdata), .o_m_rdata(o_m_rdata),
        .o_m_rvalid(o_m_rvalid), .o_s_addr(o_s_addr), .o_s_write(o_s_write),
        .o_s_read(o_s_read), .o_s_size(o_s_size), .o_s_wdata(o_s_wdata),
        .i_s_rdata(i_s_rdata), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int rr_pick(input logic [2:0] r, input int from, input int excl);
        for (int k = 1; k <= NM; k++) begin
            int c;
            c = (from + k) % NM;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    function automatic logic [2:0] model_gnt();
        return (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = NM - 1;
        m_run   = 0;
        m_pend  = -1;
    endtask

    task automatic model_edge();
        int np, w;
        logic [2:0] om;
        np = (m_owner >= 0 && i_m_read[m_owner]) ? m_owner : -1;
        om = model_gnt();
        if (m_owner < 0) begin
            w = rr_pick(i_req, m_last, -1);
            if (w >= 0) begin m_owner = w; m_last = w; end
            m_run = 0;
        end else if (!i_req[m_owner]) begin
            w = rr_pick(i_req, m_last, m_owner);
            m_owner = w;
            if (w >= 0) m_last = w;
            m_run = 0;
        end else if ((i_req & ~om) == 3'b000) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == MAX_HOLD) begin
                w = rr_pick(i_req, m_last, m_owner);
                m_owner = w;
                m_last = w;
                m_run = 0;
            end
        end
        m_pend = np;
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_req = '0; i_m_addr = '0; i_m_write = '0; i_m_read = '0;
        i_m_size = '0; i_m_wdata = '0; i_s_rdata = '0;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        i_m_addr = {3{32'hA5A5_5A5A}}; i_m_read = 3'b111; i_m_write = 3'b111;
        i_m_size = 12'hFFF; i_m_wdata = {3{32'h1234_5678}}; i_s_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk); #1;
        n_checks++; if (o_gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=000", o_gnt); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        n_checks++; if (o_m_rvalid !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=000", o_m_rvalid); end
        n_checks++; if (o_m_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", o_m_rdata); end
        n_checks++;
        if ({o_s_addr, o_s_write, o_s_read, o_s_size, o_s_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_slave got addr=%h w=%b r=%b size=%h wd=%h exp=all zero",
                               o_s_addr, o_s_write, o_s_read, o_s_size, o_s_wdata);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp;
        apply_reset();
        i_req = 3'b111;
        for (int k = 1; k <= 49; k++) begin
            tick(); #1;
            n_checks++;
            if (o_gnt !== model_gnt()) begin
                n_fail++; $display("FAIL rot_model k=%0d got=%b exp=%b", k, o_gnt, model_gnt());
            end
            if (k == 1 || k == 16 || k == 17 || k == 33 || k == 49) begin
                case (k)
                    17:      exp = 3'b010;
                    33:      exp = 3'b100;
                    default: exp = 3'b001;
                endcase
                n_checks++;
                if (o_gnt !== exp) begin n_fail++; $display("FAIL rot_point k=%0d got=%b exp=%b", k, o_gnt, exp); end
            end
        end
    endtask

    task automatic test_dma_write();
        apply_reset();
        i_m_addr  = {32'h4000_0040, 32'h1111_1111, 32'h2222_2222};
        i_m_wdata = {32'hDEAD_BEEF, 32'h3333_3333, 32'h4444_4444};
        i_m_write = 3'b101;
        i_m_size  = {4'hF, 4'h3, 4'h1};
        i_req[MST_DMA] = 1'b1;
        #1;
        n_checks++; if (o_gnt !== 3'b000 || o_s_write !== 1'b0 || o_s_addr !== '0) begin
            n_fail++; $display("FAIL dma_pregrant got gnt=%b w=%b addr=%h exp 000/0/0", o_gnt, o_s_write, o_s_addr);
        end
        tick(); #1;
        n_checks++; if (o_gnt !== 3'b100) begin n_fail++; $display("FAIL dma_gnt got=%b exp=100", o_gnt); end
        n_checks++; if (o_s_addr !== 32'h4000_0040) begin n_fail++; $display("FAIL dma_addr got=%h exp=40000040", o_s_addr); end
        n_checks++; if (o_s_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dma_wdata got=%h exp=deadbeef", o_s_wdata); end
        n_checks++; if (o_s_write !== 1'b1 || o_s_read !== 1'b0) begin
            n_fail++; $display("FAIL dma_strobes got w=%b r=%b exp w=1 r=0", o_s_write, o_s_read);
        end
        n_checks++; if (o_s_size !== 4'hF) begin n_fail++; $display("FAIL dma_size got=%h exp=f", o_s_size); end
        n_checks++; if (o_m_rvalid !== 3'b000 || o_m_rdata !== '0) begin
            n_fail++; $display("FAIL dma_rd_idle got rv=%b rd=%h exp 0", o_m_rvalid, o_m_rdata);
        end
    endtask

    task automatic test_read_return();
        logic [XLEN-1:0] rd;
        apply_reset();
        i_req[MST_DMEM] = 1'b1;
        tick(); #1;
        n_checks++; if (o_gnt !== 3'b010) begin n_fail++; $display("FAIL rd_gnt_dmem got=%b exp=010", o_gnt); end
        i_m_read[MST_DMEM] = 1'b1;
        i_m_addr[MST_DMEM*XLEN +: XLEN] = 32'h1000_0004;
        i_req = 3'b001;
        #1;
        n_checks++; if (o_s_read !== 1'b1 || o_s_addr !== 32'h1000_0004) begin
            n_fail++; $display("FAIL rd_issue got r=%b addr=%h exp r=1 addr=10000004", o_s_read, o_s_addr);
        end
        tick();
        i_m_read = 3'b000;
        rd = $urandom;
        i_s_rdata = rd;
        #1;
        n_checks++; if (o_gnt !== 3'b001) begin n_fail++; $display("FAIL rd_gnt_spi got=%b exp=001", o_gnt); end
        n_checks++; if (o_m_rvalid !== 3'b010) begin n_fail++; $display("FAIL rd_rvalid got=%b exp=010", o_m_rvalid); end
        n_checks++; if (o_m_rdata !== {32'h0, rd, 32'h0}) begin
            n_fail++; $display("FAIL rd_rdata got=%h exp=%h", o_m_rdata, {32'h0, rd, 32'h0});
        end
        tick(); #1;
        n_checks++; if (o_m_rvalid !== 3'b000) begin n_fail++; $display("FAIL rd_rvalid_once got=%b exp=000", o_m_rvalid); end
    endtask

    task automatic test_hold_saturate();
        int bad;
        apply_reset();
        i_req = 3'b001;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick(); #1;
            if (o_gnt !== 3'b001) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_alone got=%0d bad cycles exp=0", bad); end
        i_req = 3'b101;
        for (int k = 1; k <= 16; k++) begin
            tick(); #1;
            n_checks++;
            if (o_gnt !== ((k < 16) ? 3'b001 : 3'b100)) begin
                n_fail++; $display("FAIL hold_preempt k=%0d got=%b exp=%b", k, o_gnt, (k < 16) ? 3'b001 : 3'b100);
            end
        end
    endtask

    task automatic test_release_idle();
        apply_reset();
        i_m_addr = {3{32'hCAFE_0000}}; i_m_wdata = {3{32'h0BAD_F00D}};
        i_m_write = 3'b111; i_m_read = 3'b111; i_m_size = 12'hFFF;
        i_req[MST_DMEM] = 1'b1;
        tick(); #1;
        n_checks++; if (o_gnt !== 3'b010) begin n_fail++; $display("FAIL rel_gnt got=%b exp=010", o_gnt); end
        i_req = 3'b000;
        tick(); #1;
        n_checks++; if (o_gnt !== 3'b000 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL rel_idle got gnt=%b busy=%b exp 000/0", o_gnt, o_busy);
        end
        n_checks++;
        if ({o_s_addr, o_s_write, o_s_read, o_s_size, o_s_wdata} !== '0) begin
            n_fail++; $display("FAIL rel_slave got addr=%h w=%b r=%b size=%h wd=%h exp=all zero",
                               o_s_addr, o_s_write, o_s_read, o_s_size, o_s_wdata);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        i_req = 3'b001;
        i_m_read[MST_SPI] = 1'b1;
        tick(); tick(); #1;
        n_checks++; if (o_m_rvalid !== 3'b001) begin n_fail++; $display("FAIL midrst_pend got=%b exp=001", o_m_rvalid); end
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++; if (o_gnt !== 3'b000 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_gnt got gnt=%b busy=%b exp 000/0", o_gnt, o_busy);
        end
        n_checks++; if (o_m_rvalid !== 3'b000) begin n_fail++; $display("FAIL midrst_rvalid got=%b exp=000", o_m_rvalid); end
        clear_inputs();
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_req = 3'b111;
        tick(); #1;
        n_checks++; if (o_gnt !== 3'b001) begin n_fail++; $display("FAIL midrst_first got=%b exp=001", o_gnt); end
    endtask

    task automatic test_random();
        logic [XLEN-1:0]    e_addr, e_wdata;
        logic               e_w, e_r;
        logic [3:0]         e_size;
        logic [NM*XLEN-1:0] e_rdata;
        logic [2:0]         e_rv;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < NM; m++) if ($urandom_range(0, 7) == 0) i_req[m] = ~i_req[m];
            i_m_read  = 3'($urandom);
            i_m_write = 3'($urandom);
            i_m_addr  = {$urandom, $urandom, $urandom};
            i_m_wdata = {$urandom, $urandom, $urandom};
            i_m_size  = 12'($urandom);
            i_s_rdata = $urandom;
            #1;
            e_addr = '0; e_wdata = '0; e_w = 1'b0; e_r = 1'b0; e_size = '0;
            if (m_owner >= 0) begin
                e_addr  = i_m_addr[m_owner*XLEN +: XLEN];
                e_wdata = i_m_wdata[m_owner*XLEN +: XLEN];
                e_w     = i_m_write[m_owner];
                e_r     = i_m_read[m_owner];
                e_size  = i_m_size[m_owner*4 +: 4];
            end
            e_rdata = '0;
            e_rv    = 3'b000;
            if (m_pend >= 0) begin
                e_rv = 3'(1 << m_pend);
                e_rdata[m_pend*XLEN +: XLEN] = i_s_rdata;
            end
            n_checks++; if (o_gnt !== model_gnt()) begin
                n_fail++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, o_gnt, model_gnt());
            end
            n_checks++; if (o_busy !== (m_owner >= 0)) begin
                n_fail++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, o_busy, m_owner >= 0);
            end
            n_checks++; if ({o_s_addr, o_s_write, o_s_read, o_s_size, o_s_wdata} !== {e_addr, e_w, e_r, e_size, e_wdata}) begin
                n_fail++; $display("FAIL rnd_slave c=%0d got=%h/%b/%b/%h/%h exp=%h/%b/%b/%h/%h", c,
                                   o_s_addr, o_s_write, o_s_read, o_s_size, o_s_wdata, e_addr, e_w, e_r, e_size, e_wdata);
            end
            n_checks++; if (o_m_rvalid !== e_rv) begin
                n_fail++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, o_m_rvalid, e_rv);
            end
            n_checks++; if (o_m_rdata !== e_rdata) begin
                n_fail++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, o_m_rdata, e_rdata);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_dma_write();
        test_read_return();
        test_hold_saturate();
        test_release_idle();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ids_bus_arbiter.md
Name: ids_bus_arbiter

Overview:
Shares the single data-side port of the IDS bus between the bus masters: SPI slave, RV DMEM and DMA. The instruction port is separate and not arbitrated.
- Round-robin arbitration with registered grants.
- Bounded hold time so that no master starves another.
- Muxes the owner's access onto one slave-side port.
- Routes 1-cycle-latency read data back to the master that issued the read.
- Sits between the masters and the ids_bus address decoder.

Parameters:
XLEN, 32, data/address width
N_MST, 3, number of masters (index 0=SPI, 1=DMEM, 2=DMA)
MAX_HOLD, 16, maximum consecutive granted cycles while another master is requesting
RD_LAT, 1, slave read latency in cycles (only 1 is supported)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  N_MST  request per master, held until its access is done
o_gnt  out  N_MST  registered one-hot grant
i_m_addr  in  N_MST*XLEN  per-master address, flattened, master m at [m*XLEN +: XLEN]
i_m_write  in  N_MST  per-master write strobe
i_m_read  in  N_MST  per-master read strobe
i_m_size  in  N_MST*4  per-master byte enable
i_m_wdata  in  N_MST*XLEN  per-master write data
o_m_rdata  out  N_MST*XLEN  per-master read data
o_m_rvalid  out  N_MST  read data valid, one cycle
o_s_addr  out  XLEN  slave-side address
o_s_write  out  1  slave-side write strobe
o_s_read  out  1  slave-side read strobe
o_s_size  out  4  slave-side byte enable
o_s_wdata  out  XLEN  slave-side write data
i_s_rdata  in  XLEN  slave read data, valid RD_LAT cycles after o_s_read
o_busy  out  1  a grant is active

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - o_gnt=0, o_busy=0, o_m_rvalid=0.
  - Hold counter=0; rd_pend=0.
  - last_winner=N_MST-1, so master 0 wins the first contested arbitration.
  - All slave-side outputs are 0 while no grant is held.
- State: IDLE (no owner), OWN (owner = index of the set o_gnt bit).
- Arbitration function (rr_picker):
  - Searches the req vector starting at last_winner+1 and wrapping modulo N_MST.
  - Returns the first set bit; valid=0 if no requests.
- Transitions, evaluated each clock edge:
  - IDLE: any i_req -> OWN with the picked winner. o_gnt is set at that edge (1-cycle grant latency). last_winner=winner; counter=0.
  - OWN, owner's i_req=0 -> re-arbitrate among the other masters in the same edge (no bubble). No other request -> IDLE.
  - OWN, owner still requesting, no other request -> stay; counter saturates at MAX_HOLD.
  - OWN, owner requesting and another master requesting -> counter++. When counter==MAX_HOLD-1 at the edge, the grant moves to the rr winner that excludes the owner; counter=0.
  - A preempted master keeps i_req high and re-presents its access when re-granted. An access not granted in a cycle has no effect.
- Slave-side mux:
  - o_s_* = owner's i_m_* when o_gnt is nonzero; otherwise all zero.
  - Combinational from the registered o_gnt.
- Read return:
  - On a cycle with o_s_read=1, register rd_pend=1 and rd_owner=owner.
  - Next cycle: o_m_rvalid[rd_owner]=1 and o_m_rdata[rd_owner]=i_s_rdata; all other o_m_rdata=0.
  - Read return completes even if the grant changed meanwhile.
- Simultaneous events: owner release plus new requests in the same cycle -> new owner takes the grant at that edge; the old owner's read return is still delivered.
- Reset mid-operation: everything is cleared immediately. An in-flight read is dropped (no rvalid).
- o_busy = |o_gnt.

Decomposition:
- ids_bus_pkg holds:
  - MST_SPI=0, MST_DMEM=1, MST_DMA=2.
  - N_MST.
  - Enum arb_state_t {ARB_IDLE, ARB_OWN}.
- One sub-module, ids_rr_picker: combinational round-robin pick.
  - Inputs: req vector, last index, exclude mask.
  - Outputs: winner index, valid.

Test Plan:
1. Reset, then i_req=3'b111 held -> gnt=001 one cycle later. Pattern after 16 cycles: 010, after 32: 100, after 48: 001 (rotation every MAX_HOLD).
2. Only DMA requests a write to addr 0x4000_0040, data 0xDEAD_BEEF -> gnt=100 next cycle; o_s_addr/o_s_wdata/o_s_write match in the granted cycle; other outputs are 0.
3. DMEM granted, issues a read to 0x1000_0004 and drops req the same cycle; SPI is requesting -> next cycle gnt=001. o_m_rvalid[1]=1 with o_m_rdata[1]=i_s_rdata; o_m_rvalid[0]=0.
4. SPI alone holds req for 40 cycles -> gnt stays 001 and counter saturates. DMA asserts req at cycle 40 -> gnt=100 exactly 16 cycles later.
5. Owner releases with no other requests -> o_gnt=0 and o_busy=0 next cycle; o_s_* all 0.
6. Assert i_rst_n=0 asynchronously while a read is pending -> o_gnt=0 and o_m_rvalid=0 immediately. After release, i_req=111 -> gnt=001 first.
